// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
//
// Purpose:
//    Sits between the core's load/store port and a single-port data SRAM.
//    Takes one byte/halfword/word request at a time over a valid/ready
//    handshake, drives the SRAM with lane-aligned byte enables and write
//    data, and returns right-aligned, sign- or zero-extended load data as a
//    one-cycle response pulse. Stores also get a response pulse.
//
// Build option:
//    MISALIGN_SPLIT_EN - when defined, an access that spills into the next
//                        word is performed as two SRAM accesses (ACC0 then
//                        ACC1). When undefined, such requests are answered
//                        with RSP_ERR=1 and never touch the SRAM.
//
// Ports:
//    CLK, RST       clock; synchronous active-high reset
//    REQ_*          request channel (valid/ready, store flag, size,
//                   unsigned flag, byte address, right-aligned store data)
//    RSP_*          response pulse, extended load data, error flag
//    MEM_*          SRAM chip select / write enable (active low), word
//                   address, byte enables, write data, read data
// ---------------------------------------------------------------------------
module dmem_access_unit #(
   parameter int AWIDTH = 12
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_WE,
   input  logic [1:0]        REQ_SIZE,
   input  logic              REQ_UNSIGNED,
   input  logic [AWIDTH+1:0] REQ_ADDR,
   input  logic [31:0]       REQ_WDATA,
   output logic              RSP_VALID,
   output logic [31:0]       RSP_RDATA,
   output logic              RSP_ERR,
   output logic              MEM_CSN,
   output logic              MEM_WEN,
   output logic [AWIDTH-1:0] MEM_ADDR,
   output logic [3:0]        MEM_BE,
   output logic [31:0]       MEM_DI,
   input  logic [31:0]       MEM_DOUT
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [AWIDTH-1:0] word_q;
   logic [1:0]        off_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [31:0]       lo_q;
`ifdef MISALIGN_SPLIT_EN
   logic [31:0]       hi_q;
   logic [3:0]        acc_be_hi;
   logic [31:0]       store_hi;
`else
   logic              req_cross;
`endif

   logic              req_err;
   logic [3:0]        acc_be_lo;
   logic [31:0]       store_lo;
   logic [4:0]        shamt;
   logic [31:0]       load_win;
   logic [31:0]       load_ext;

   // Byte-lane mask over two consecutive words: the low nibble covers the
   // addressed word, the high nibble covers the following word.
   function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] off);
      logic [7:0] base;
      case (size)
         2'b00:   base = 8'h01;
         2'b01:   base = 8'h03;
         2'b10:   base = 8'h0F;
         default: base = 8'h00;
      endcase
      return base << off;
   endfunction

   assign shamt = {off_q, 3'b000};

   // Decide at handshake time whether the request can be served at all.
   // Reserved size is always rejected; a word-crossing access is only
   // rejected when the two-access split is not built in.
`ifdef MISALIGN_SPLIT_EN
   assign req_err = (REQ_SIZE == 2'b11);
   assign {acc_be_hi, acc_be_lo} = lane_mask(size_q, off_q);
   assign {store_hi, store_lo}   = {32'b0, wdata_q} << shamt;
   assign load_win               = 32'({hi_q, lo_q} >> shamt);
`else
   assign req_cross = ((lane_mask(REQ_SIZE, REQ_ADDR[1:0]) >> 4) != 8'h00);
   assign req_err   = (REQ_SIZE == 2'b11) || req_cross;
   assign acc_be_lo = 4'(lane_mask(size_q, off_q));
   assign store_lo  = wdata_q << shamt;
   assign load_win  = lo_q >> shamt;
`endif

   // Truncate the shifted-down load window to the access size and extend it.
   always_comb begin
      load_ext = 32'h0;
      case (size_q)
         2'b00:   load_ext = uns_q ? {24'h0, load_win[7:0]}
                                   : {{24{load_win[7]}}, load_win[7:0]};
         2'b01:   load_ext = uns_q ? {16'h0, load_win[15:0]}
                                   : {{16{load_win[15]}}, load_win[15:0]};
         2'b10:   load_ext = load_win;
         default: load_ext = 32'h0;
      endcase
   end

   // State register. Reset drops straight back to IDLE, abandoning any
   // request in flight without a response.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request capture and load-data latching. LO is taken at the end of the
   // first access cycle, HI at the end of the second.
   always_ff @(posedge CLK) begin
      if (RST) begin
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         word_q  <= '0;
         off_q   <= 2'b00;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
         lo_q    <= 32'h0;
`ifdef MISALIGN_SPLIT_EN
         hi_q    <= 32'h0;
`endif
      end else begin
         if ((state == IDLE) && REQ_VALID) begin
            we_q    <= REQ_WE;
            size_q  <= REQ_SIZE;
            uns_q   <= REQ_UNSIGNED;
            word_q  <= REQ_ADDR[AWIDTH+1:2];
            off_q   <= REQ_ADDR[1:0];
            wdata_q <= REQ_WDATA;
            err_q   <= req_err;
         end
         if ((state == ACC0) && !we_q) begin
            lo_q <= MEM_DOUT;
         end
`ifdef MISALIGN_SPLIT_EN
         if ((state == ACC1) && !we_q) begin
            hi_q <= MEM_DOUT;
         end
`endif
      end
   end

   // Next-state logic. Rejected requests skip the SRAM entirely and go
   // directly to the response cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (REQ_VALID) begin
               state_next = req_err ? RESP : ACC0;
            end
         end
         ACC0: begin
`ifdef MISALIGN_SPLIT_EN
            state_next = (acc_be_hi != 4'h0) ? ACC1 : RESP;
`else
            state_next = RESP;
`endif
         end
`ifdef MISALIGN_SPLIT_EN
         ACC1: state_next = RESP;
`endif
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode. Everything is held inactive while RST is high so that a
   // store caught by reset in its access cycle can never reach the SRAM.
   // The second access uses the next word address, wrapping at the top.
   always_comb begin
      REQ_READY = 1'b0;
      RSP_VALID = 1'b0;
      RSP_RDATA = 32'h0;
      RSP_ERR   = 1'b0;
      MEM_CSN   = 1'b1;
      MEM_WEN   = 1'b1;
      MEM_ADDR  = '0;
      MEM_BE    = 4'h0;
      MEM_DI    = 32'h0;
      if (!RST) begin
         case (state)
            IDLE: REQ_READY = 1'b1;
            ACC0: begin
               MEM_CSN  = 1'b0;
               MEM_WEN  = ~we_q;
               MEM_ADDR = word_q;
               MEM_BE   = acc_be_lo;
               MEM_DI   = store_lo;
            end
`ifdef MISALIGN_SPLIT_EN
            ACC1: begin
               MEM_CSN  = 1'b0;
               MEM_WEN  = ~we_q;
               MEM_ADDR = word_q + {{(AWIDTH-1){1'b0}}, 1'b1};
               MEM_BE   = acc_be_hi;
               MEM_DI   = store_hi;
            end
`endif
            RESP: begin
               RSP_VALID = 1'b1;
               RSP_ERR   = err_q;
               RSP_RDATA = (we_q || err_q) ? 32'h0 : load_ext;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Data-memory access unit placed directly upstream of the single-port data SRAM. Accepts byte/halfword/word load and store requests from the core over a valid/ready handshake, drives the SRAM chip-select, write-enable, byte-enable, address and data ports, and returns aligned, sign- or zero-extended load data as a one-cycle response pulse. Word-crossing misaligned accesses are either split into two SRAM accesses or rejected, depending on build configuration.

## Interface
- AWIDTH, 12, SRAM word-address width; request byte address is AWIDTH+2 bits
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  unit can accept a request
- REQ_WE  in  1  1 = store, 0 = load
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 reserved
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0
- REQ_ADDR  in  AWIDTH+2  byte address
- REQ_WDATA  in  32  store data, right-aligned
- RSP_VALID  out  1  one-cycle response pulse
- RSP_RDATA  out  32  extended load data; 0 for stores and errors
- RSP_ERR  out  1  request rejected, qualified by RSP_VALID
- MEM_CSN  out  1  SRAM chip select, active low
- MEM_WEN  out  1  SRAM write enable, active low
- MEM_ADDR  out  AWIDTH  SRAM word address
- MEM_BE  out  4  SRAM byte enables, bit i = byte lane i
- MEM_DI  out  32  SRAM write data
- MEM_DOUT  in  32  SRAM read data; combinational from address while selected

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: REQ_READY=1. When REQ_VALID=1, capture the request into registers. Next state:
  - ACC0 for a legal request.
  - RESP with error flag set for REQ_SIZE=11, or for a word-crossing request when splitting is not compiled in.
- Definitions: o = REQ_ADDR[1:0]; w = REQ_ADDR[AWIDTH+1:2]; lane mask M = (1, 3 or F for byte, half, word) << o, 8 bits wide; crossing when M[7:4] != 0.
- Store data: D = {32'b0, WDATA} << 8*o (64 bits).
- ACC0: MEM_CSN=0; MEM_WEN=~WE; MEM_ADDR=w; MEM_BE=M[3:0]; MEM_DI=D[31:0].
  - Load: latch MEM_DOUT into LO at the end of the cycle.
  - Next state: ACC1 if crossing, else RESP.
- ACC1: MEM_ADDR=(w+1) mod 2^AWIDTH, wrapping from the top word to word 0; MEM_BE=M[7:4]; MEM_DI=D[63:32].
  - Load: latch MEM_DOUT into HI.
  - Next state: RESP.
- RESP: RSP_VALID=1.
  - Load: RSP_RDATA = ({HI,LO} >> 8*o), truncated to the access size and extended per REQ_UNSIGNED.
  - Store: RSP_RDATA=0.
  - RSP_ERR=error flag. Next state: IDLE.
- Stores receive a response pulse the same as loads; there is no response backpressure.
- Outside ACC0/ACC1: MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_DI=0.
- A store must never write lanes outside M, so no other byte in the word is modified.

## Timing
- Request handshake at edge E0.
- Aligned or non-crossing access: ACC0 in the cycle after E0; RSP_VALID high two cycles after E0.
- Split access: RSP_VALID high three cycles after E0.
- Error: RSP_VALID high one cycle after E0; MEM_CSN stays 1 throughout.
- Throughput: one request per 3 cycles (aligned), 4 cycles (split), 2 cycles (error). REQ_READY is low in ACC0, ACC1 and RESP.
- Load data is sampled at the edge ending the access cycle. The SRAM read path plus unit input must settle within one period.
- While RST=1, all outputs are forced inactive combinationally: REQ_READY=0, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_DI=0.
- Reset mid-operation aborts the request with no response. A store whose access cycle overlaps RST=1 does not write. If ACC0 has completed, a split store's ACC1 half is lost.
- At the first edge with RST=0, the state is IDLE and REQ_READY=1 in the following cycle.

## Configuration
- MISALIGN_SPLIT_EN defined: word-crossing requests perform ACC0 then ACC1 as above.
- MISALIGN_SPLIT_EN undefined:
  - ACC1 and the HI register are removed.
  - Word-crossing requests complete as errors: RSP_ERR=1, RSP_RDATA=0, no SRAM access.
  - Non-crossing misaligned requests (e.g. a halfword at o=1) still complete normally.

## Test plan
- Word store 0xDEADBEEF to byte address 0x010, then word load from 0x010 -> store response after 2 cycles with RSP_ERR=0; load returns 0xDEADBEEF 2 cycles after its handshake.
- Byte store 0x80 to 0x013, then signed byte load and unsigned byte load from 0x013 -> store uses MEM_BE=1000; loads return 0xFFFFFF80 and 0x00000080.
- Halfword store 0xA5C3 to 0x011, then signed halfword load from 0x011 -> MEM_BE=0110, MEM_DI=0x00A5C300; load returns 0xFFFFA5C3.
- With macro on: word store 0x11223344 to 0x00E, then load from 0x00E -> ACC0 uses word 3 with BE=1100, ACC1 uses word 4 with BE=0011; load returns 0x11223344 3 cycles after handshake. With macro off: RSP_ERR=1 after 1 cycle and MEM_CSN is never low.
- Wrap case (macro on): word store to the last word address at o=2 -> ACC1 MEM_ADDR=0 with MEM_BE=0011.
- Assert RST during ACC0 of a store -> no SRAM write (word readback unchanged), no RSP_VALID, REQ_READY=1 one cycle after RST is deasserted.
